mdu: RTL and testbench

Multiply/divide unit in the E stage of the pipelined MIPS core. It owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo. It drives `busy` to the hazard/stall unit, which freezes F/D while a long operation is in flight. The stall unit holds back mult/div/mfhi/mflo/mthi/mtlo in D while a mult/div sits in E or `busy` is high. This block is the responder side of that stall handshake.

---
 rtl/mdu.sv | 126 ++++++++++++
 tb/tb_mdu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div with a fixed
// busy window and commits the full result atomically when the window closes.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
   localparam int unsigned CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      pend_hi, pend_lo;
   logic [31:0]      hi_n, lo_n, pend_hi_n, pend_lo_n;

   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] rs_mag, rt_mag, num, den, den_safe, quo, rem, quo_fix, rem_fix;

   // The run window is fully described by the counter.
   assign state  = (cnt == '0) ? IDLE : RUN;
   assign busy   = (state == RUN);
   assign rd_out = hilo_sel ? hi : lo;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed division on magnitudes, so 0x80000000 / -1 wraps back to 0x80000000.
   assign div_signed = (md_op == OP_DIV);
   assign rs_mag     = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
   assign rt_mag     = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
   assign num        = div_signed ? rs_mag : rs_val;
   assign den        = div_signed ? rt_mag : rt_val;
   assign den_safe   = (den == 32'd0) ? 32'd1 : den;
   assign quo        = num / den_safe;
   assign rem        = num % den_safe;
   assign quo_fix    = (div_signed && (rs_val[31] ^ rt_val[31])) ? (~quo + 32'd1) : quo;
   assign rem_fix    = (div_signed && rs_val[31]) ? (~rem + 32'd1) : rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         cnt     <= cnt_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
      end
   end

   always_comb begin
      cnt_n     = cnt;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      case (state)
         IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT: begin
                     pend_hi_n = prod_s[63:32];
                     pend_lo_n = prod_s[31:0];
                     cnt_n     = CNT_W'(MULT_CYCLES);
                  end
                  OP_MULTU: begin
                     pend_hi_n = prod_u[63:32];
                     pend_lo_n = prod_u[31:0];
                     cnt_n     = CNT_W'(MULT_CYCLES);
                  end
                  OP_DIV, OP_DIVU: begin
                     // Zero divisor re-commits the current HI/LO.
                     if (rt_val == 32'd0) begin
                        pend_hi_n = hi;
                        pend_lo_n = lo;
                     end else begin
                        pend_hi_n = rem_fix;
                        pend_lo_n = quo_fix;
                     end
                     cnt_n = CNT_W'(DIV_CYCLES);
                  end
                  OP_MTHI: hi_n = rs_val;
                  OP_MTLO: lo_n = rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               hi_n = pend_hi;
               lo_n = pend_lo;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus random traffic against
// an arithmetic reference model of HI/LO and the busy window.
module tb_mdu;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset, start, hilo_sel;
   logic [2:0]  md_op;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi, lo, rd_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
   int          m_left = 0;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .hilo_sel(hilo_sel),
      .busy(busy), .hi(hi), .lo(lo), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   // Advance model by one edge using the inputs currently applied, then clock the DUT.
   task automatic cycle();
      longint          a, b, q, r;
      longint unsigned pu;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
      end else if (m_left != 0) begin
         m_left--;
         if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (start) begin
         case (md_op)
            3'd0: begin
               a = longint'($signed(rs_val)); b = longint'($signed(rt_val)); q = a * b;
               m_phi = q[63:32]; m_plo = q[31:0]; m_left = MC;
            end
            3'd1: begin
               pu = 64'(rs_val) * 64'(rt_val);
               m_phi = pu[63:32]; m_plo = pu[31:0]; m_left = MC;
            end
            3'd2: begin
               if (rt_val == 0) begin m_phi = m_hi; m_plo = m_lo; end
               else begin
                  a = longint'($signed(rs_val)); b = longint'($signed(rt_val));
                  q = a / b; r = a % b;
                  m_phi = r[31:0]; m_plo = q[31:0];
               end
               m_left = DC;
            end
            3'd3: begin
               if (rt_val == 0) begin m_phi = m_hi; m_plo = m_lo; end
               else begin m_phi = rs_val % rt_val; m_plo = rs_val / rt_val; end
               m_left = DC;
            end
            3'd4: m_hi = rs_val;
            3'd5: m_lo = rs_val;
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      reset    = 1'b0;
      hilo_sel = 1'($urandom);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_op = op; rs_val = a; rt_val = b; start = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_mult();
      int nb = 0;
      issue(3'd0, 32'hFFFFFFFD, 32'd5);
      for (int i = 0; i < MC + 3; i++) begin
         if (busy === 1'b1) nb++;
         vectors++;
         if (busy !== (m_left != 0) || rd_out !== (hilo_sel ? m_hi : m_lo)) begin
            miscompares++;
            $display("FAIL mult_run cyc=%0d busy=%b exp=%b rd_out=%h exp=%h", i, busy, m_left != 0, rd_out, hilo_sel ? m_hi : m_lo);
         end
         cycle();
      end
      vectors++;
      if (nb != MC || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
         miscompares++;
         $display("FAIL mult_result busy_cycles=%0d exp=%0d hi=%h lo=%h exp=ffffffff/fffffff1", nb, MC, hi, lo);
      end
   endtask

   task automatic test_multu_div();
      issue(3'd1, 32'hFFFFFFFF, 32'd2);
      for (int i = 0; i < MC; i++) cycle();
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
         miscompares++;
         $display("FAIL multu busy=%b hi=%h lo=%h exp=0/00000001/fffffffe", busy, hi, lo);
      end
      issue(3'd2, 32'hFFFFFFF9, 32'd2);
      for (int i = 0; i < DC; i++) begin
         vectors++;
         if (busy !== 1'b1 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            miscompares++;
            $display("FAIL div_run cyc=%0d busy=%b hi=%h lo=%h exp=1/00000001/fffffffe", i, busy, hi, lo);
         end
         cycle();
      end
      vectors++;
      if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
         miscompares++;
         $display("FAIL div_result busy=%b hi=%h lo=%h exp=0/ffffffff/fffffffd", busy, hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo_divzero();
      issue(3'd4, 32'h12345678, 32'h0);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h12345678) begin
         miscompares++;
         $display("FAIL mthi busy=%b hi=%h exp=0/12345678", busy, hi);
      end
      issue(3'd5, 32'h9ABCDEF0, 32'h0);
      vectors++;
      if (busy !== 1'b0 || lo !== 32'h9ABCDEF0) begin
         miscompares++;
         $display("FAIL mtlo busy=%b lo=%h exp=0/9abcdef0", busy, lo);
      end
      issue(3'd3, 32'hCAFEF00D, 32'h0);
      for (int i = 0; i < DC + 2; i++) begin
         vectors++;
         if (busy !== (i < DC) || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL divu_zero cyc=%0d busy=%b hi=%h lo=%h exp=%b/12345678/9abcdef0", i, busy, hi, lo, i < DC);
         end
         cycle();
      end
   endtask

   task automatic test_start_during_run();
      int nb = 0;
      logic [31:0] a = $urandom, b = $urandom;
      issue(3'd0, a, b);
      for (int i = 0; i < MC + 3; i++) begin
         if (busy === 1'b1) nb++;
         vectors++;
         if (busy !== (m_left != 0) || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL run_ignore cyc=%0d busy=%b exp=%b hi=%h exp=%h lo=%h exp=%h", i, busy, m_left != 0, hi, m_hi, lo, m_lo);
         end
         if (i == 1) begin md_op = 3'd5; rs_val = 32'hDEAD; start = 1'b1; end
         if (i == 2) begin md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1; end
         cycle();
      end
      vectors++;
      if (nb != MC) begin
         miscompares++;
         $display("FAIL run_ignore_len busy_cycles=%0d exp=%0d", nb, MC);
      end
   endtask

   task automatic test_reset_mid_div();
      issue(3'd4, 32'h11111111, 32'h0);
      issue(3'd5, 32'h22222222, 32'h0);
      issue(3'd2, 32'd1000, 32'd7);
      cycle();
      cycle();
      reset = 1'b1; md_op = 3'd4; rs_val = 32'hFFFF0000; start = 1'b1;
      cycle();
      for (int i = 0; i < DC + 2; i++) begin
         vectors++;
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid cyc=%0d busy=%b hi=%h lo=%h exp=0/0/0", i, busy, hi, lo);
         end
         cycle();
      end
   endtask

   task automatic test_overflow_back_to_back();
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      for (int i = 0; i < DC; i++) cycle();
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h80000000) begin
         miscompares++;
         $display("FAIL div_ovf busy=%b hi=%h lo=%h exp=0/00000000/80000000", busy, hi, lo);
      end
      issue(3'd1, 32'd6, 32'd7);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL back_to_back busy=%b exp=1", busy);
      end
      for (int i = 0; i < MC; i++) cycle();
      vectors++;
      if (hi !== 32'd0 || lo !== 32'd42) begin
         miscompares++;
         $display("FAIL back_to_back_res hi=%h lo=%h exp=0/0000002a", hi, lo);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         vectors++;
         if (busy !== (m_left != 0) || hi !== m_hi || lo !== m_lo || rd_out !== (hilo_sel ? m_hi : m_lo)) begin
            miscompares++;
            $display("FAIL random cyc=%0d busy=%b exp=%b hi=%h exp=%h lo=%h exp=%h rd_out=%h", i, busy, m_left != 0, hi, m_hi, lo, m_lo, rd_out);
         end
         if ($urandom_range(0, 2) == 0) begin
            md_op = 3'($urandom_range(0, 7)); rs_val = pick_operand(); rt_val = pick_operand(); start = 1'b1;
         end
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         cycle();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; hilo_sel = 1'b0;
      #2;
      test_reset();
      test_mult();
      test_multu_div();
      test_mthi_mtlo_divzero();
      test_start_during_run();
      test_reset_mid_div();
      test_overflow_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
